// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared encodings for the RV32 execute stage (ALU ops, divide ops,
//             forward selects, divider state).
//  Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] DIVOP_DIV  = 2'b00;
    localparam logic [1:0] DIVOP_DIVU = 2'b01;
    localparam logic [1:0] DIVOP_REM  = 2'b10;
    localparam logic [1:0] DIVOP_REMU = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic divop_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic divop_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
//  Module   : div_unit
//  Purpose  : Restoring divider (one quotient bit per cycle) with IDLE/BUSY/DONE
//             handshake for DIV/DIVU/REM/REMU. rst is asynchronous, active-low.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module div_unit
    import riscv_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    div_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_dividend;
    logic [1:0]      r_op;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div_zero;

    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_q_signed;
    logic [XLEN-1:0] w_r_signed;

    assign w_sa    = divop_is_signed(i_op) & i_a[XLEN-1];
    assign w_sb    = divop_is_signed(i_op) & i_b[XLEN-1];
    assign w_mag_a = w_sa ? (~i_a + 1'b1) : i_a;
    assign w_mag_b = w_sb ? (~i_b + 1'b1) : i_b;

    // Dividend bits shift out of r_quo into the partial remainder as quotient bits shift in.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};
    assign w_ge    = (w_shift >= {1'b0, r_divisor});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= DIV_IDLE;
            r_cnt      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_op       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (i_start) begin
                        r_state    <= DIV_BUSY;
                        r_cnt      <= '0;
                        r_quo      <= w_mag_a;
                        r_rem      <= '0;
                        r_divisor  <= w_mag_b;
                        r_dividend <= i_a;
                        r_op       <= i_op;
                        r_neg_q    <= w_sa ^ w_sb;
                        r_neg_r    <= w_sa;
                        r_div_zero <= (i_b == '0);
                    end
                end
                DIV_BUSY: begin
                    r_quo <= {r_quo[XLEN-2:0], w_ge};
                    r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(DIV_CYCLES - 1)) begin
                        r_state <= DIV_DONE;
                    end
                end
                DIV_DONE: r_state <= DIV_IDLE;
                default:  r_state <= DIV_IDLE;
            endcase
        end
    end

    assign w_q_signed = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_signed = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    // Divide-by-zero bypasses sign fix-up so DIV x/0 stays all-ones regardless of sign.
    always_comb begin
        if (r_div_zero) begin
            o_result = divop_is_rem(r_op) ? r_dividend : '1;
        end else begin
            o_result = divop_is_rem(r_op) ? w_r_signed : w_q_signed;
        end
    end

    assign o_done  = (r_state == DIV_DONE);
    assign o_stall = rst & (((r_state == DIV_IDLE) & i_start) | (r_state == DIV_BUSY));

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
//  Module   : execute_stage
//  Purpose  : RV32 EX stage: forwarding, ALU, branch target, optional divider
//             (enabled by defining RV32M_DIV_EN) and EX/MEM register.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module execute_stage
    import riscv_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic            ALUSrcE,
    input  logic            DivE,
    input  logic [1:0]      DivOpE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            ZeroE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            StallEX,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_m_result;
    logic            w_stall;

    always_comb begin
        case (ForwardAE)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = ALUResultM;
            default: w_src_a = RD1_E;
        endcase
        case (ForwardBE)
            FWD_WB:  w_fwd_b = ResultW;
            FWD_MEM: w_fwd_b = ALUResultM;
            default: w_fwd_b = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

    always_comb begin
        w_alu_result = '0;
        case (ALUControlE)
            ALU_ADD:   w_alu_result = w_src_a + w_src_b;
            ALU_SUB:   w_alu_result = w_src_a - w_src_b;
            ALU_AND:   w_alu_result = w_src_a & w_src_b;
            ALU_OR:    w_alu_result = w_src_a | w_src_b;
            ALU_XOR:   w_alu_result = w_src_a ^ w_src_b;
            ALU_SLT:   w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            ALU_SLTU:  w_alu_result = {{(XLEN-1){1'b0}}, (w_src_a < w_src_b)};
            ALU_SLL:   w_alu_result = w_src_a << w_src_b[4:0];
            ALU_SRL:   w_alu_result = w_src_a >> w_src_b[4:0];
            ALU_SRA:   w_alu_result = $unsigned($signed(w_src_a) >>> w_src_b[4:0]);
            ALU_PASSB: w_alu_result = w_src_b;
            default:   w_alu_result = '0;
        endcase
    end

    assign ZeroE     = (w_alu_result == '0);
    assign PCTargetE = PCE + Imm_Ext_E;

`ifdef RV32M_DIV_EN
    logic            w_div_done;
    logic [XLEN-1:0] w_div_result;

    div_unit #(
        .XLEN       (XLEN),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (DivE),
        .i_op     (DivOpE),
        .i_a      (w_src_a),
        .i_b      (w_src_b),
        .o_stall  (w_stall),
        .o_done   (w_div_done),
        .o_result (w_div_result)
    );

    assign w_m_result = w_div_done ? w_div_result : w_alu_result;
`else
    logic w_unused_divop;
    assign w_unused_divop = ^DivOpE;
    assign w_stall        = 1'b0;
    // Without the divider a divide still retires, writing zero to rd.
    assign w_m_result     = DivE ? '0 : w_alu_result;
`endif

    assign StallEX = w_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            RdM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else if (w_stall) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            RdM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            ALUResultM <= w_m_result;
            WriteDataM <= w_fwd_b;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
//  Module   : tb_execute_stage
//  Purpose  : Self-checking bench for execute_stage against an arithmetic
//             reference model; divider scenarios when RV32M_DIV_EN is defined.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_execute_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteE = 0, MemWriteE = 0, ALUSrcE = 0, DivE = 0;
    logic [1:0]  ResultSrcE = 0, DivOpE = 0, ForwardAE = 0, ForwardBE = 0;
    logic [3:0]  ALUControlE = 0;
    logic [31:0] RD1_E = 0, RD2_E = 0, Imm_Ext_E = 0, PCE = 0, PCPlus4E = 0, ResultW = 0;
    logic [4:0]  RdE = 0;
    logic        ZeroE, StallEX, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] m_alu = 0;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .DivE(DivE), .DivOpE(DivOpE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .ZeroE(ZeroE), .PCTargetE(PCTargetE), .StallEX(StallEX),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    // Reference ALU computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb, p;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = longint'(1) << int'(b[4:0]);
        case (op)
            ALU_ADD:   return 32'(ua + ub);
            ALU_SUB:   return 32'(ua - ub);
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (ua < ub) ? 32'd1 : 32'd0;
            ALU_SLL:   return 32'(ua * p);
            ALU_SRL:   return 32'(ua / p);
            ALU_SRA:   return (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
            ALU_PASSB: return b;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] rf, input logic [31:0] wb);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return m_alu;
        return rf;
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic exec_alu(input string name, input logic [3:0] op, input logic [31:0] rd1,
                            input logic [31:0] rd2, input logic [31:0] imm, input logic alusrc,
                            input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] resw);
        logic [31:0] a, fwdb, b, exp, pc, pc4;
        logic [8:0]  ctrl;
        pc  = $urandom;
        pc4 = $urandom;
        ctrl = 9'($urandom);
        {RegWriteE, MemWriteE, ResultSrcE, RdE} = ctrl;
        DivE = 0; ALUControlE = op; RD1_E = rd1; RD2_E = rd2; Imm_Ext_E = imm;
        ALUSrcE = alusrc; ForwardAE = fa; ForwardBE = fb; ResultW = resw;
        PCE = pc; PCPlus4E = pc4;
        a    = fwd_val(fa, rd1, resw);
        fwdb = fwd_val(fb, rd2, resw);
        b    = alusrc ? imm : fwdb;
        exp  = ref_alu(op, a, b);
        @(negedge clk);
        tests_run++;
        if (ZeroE !== (exp == 32'd0)) begin
            tests_failed++;
            $display("FAIL %s ZeroE: got %b expected %b", name, ZeroE, exp == 32'd0);
        end
        tests_run++;
        if (PCTargetE !== 32'(longint'(pc) + longint'(imm))) begin
            tests_failed++;
            $display("FAIL %s PCTargetE: got %h expected %h", name, PCTargetE, 32'(longint'(pc) + longint'(imm)));
        end
        @(posedge clk); #1;
        tests_run++;
        if ({RegWriteM, MemWriteM, ResultSrcM, RdM} !== ctrl) begin
            tests_failed++;
            $display("FAIL %s ctrlM: got %h expected %h", name, {RegWriteM, MemWriteM, ResultSrcM, RdM}, ctrl);
        end
        check32({name, " ALUResultM"}, ALUResultM, exp);
        tests_run++;
        if ({WriteDataM, PCPlus4M} !== {fwdb, pc4}) begin
            tests_failed++;
            $display("FAIL %s WriteData/PCPlus4M: got %h/%h expected %h/%h", name, WriteDataM, PCPlus4M, fwdb, pc4);
        end
        m_alu = exp;
    endtask

    task automatic test_reset;
        rst = 0; DivE = 1; RegWriteE = 1; RdE = 5'd7; RD1_E = 32'h1234; PCPlus4E = 32'h44;
        #2;
        tests_run++;
        if (StallEX !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset StallEX: got %b expected 0", StallEX);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M} !== '0) begin
            tests_failed++;
            $display("FAIL reset outputs: got %h/%h/%h expected all 0", RdM, ALUResultM, PCPlus4M);
        end
        DivE = 0; RegWriteE = 0; RdE = 0;
        rst = 1;
        m_alu = 0;
    endtask

    task automatic test_alu_directed;
        exec_alu("add_imm", ALU_ADD, 32'd5, 32'h0, 32'hFFFFFFF9, 1'b1, FWD_REG, FWD_REG, 32'h0);
        check32("add_imm const", ALUResultM, 32'hFFFFFFFE);
        exec_alu("sra_neg", ALU_SRA, 32'h80000010, 32'd4, 32'h0, 1'b0, FWD_REG, FWD_REG, 32'h0);
        check32("sra const", ALUResultM, 32'hF8000001);
        exec_alu("slt_neg", ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, FWD_REG, FWD_REG, 32'h0);
        exec_alu("sltu_big", ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, FWD_REG, FWD_REG, 32'h0);
        exec_alu("lui", ALU_PASSB, 32'h55, 32'h0, 32'hABCDE000, 1'b1, FWD_REG, FWD_REG, 32'h0);
    endtask

    task automatic test_forward;
        exec_alu("fwd_setup", ALU_ADD, 32'h10, 32'h0, 32'h0, 1'b0, FWD_REG, FWD_REG, 32'h0);
        exec_alu("fwd_mem_sub", ALU_SUB, 32'h99, 32'h10, 32'h0, 1'b0, FWD_MEM, FWD_REG, 32'h0);
        check32("fwd_mem_sub const", ALUResultM, 32'h0);
        exec_alu("fwd_11_as_reg", ALU_OR, 32'h0F0, 32'h00F, 32'h0, 1'b0, 2'b11, 2'b11, 32'hFFFF);
        exec_alu("fwd_wb_b", ALU_XOR, 32'hA5A5, 32'h0, 32'h1, 1'b1, FWD_REG, FWD_WB, 32'h3C3C);
    endtask

    task automatic test_random_alu;
        for (int i = 0; i < 60; i++) begin
            exec_alu("rand_alu", 4'($urandom_range(0, 10)), $urandom, $urandom,
                     (i % 7 == 0) ? 32'd0 : $urandom, 1'($urandom), 2'($urandom),
                     2'($urandom), $urandom);
        end
    endtask

`ifdef RV32M_DIV_EN
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
        case (op)
            DIVOP_DIVU: return a / b;
            DIVOP_REMU: return a % b;
            DIVOP_DIV:  return (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(ia / ib);
            default:    return (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib);
        endcase
    endfunction

    task automatic exec_div(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic drain);
        logic [31:0] exp;
        logic [4:0]  rd;
        int stalls, bad_bubble;
        bit done;
        exp = ref_div(op, a, b);
        rd  = 5'($urandom_range(1, 31));
        DivE = 1; DivOpE = op; ALUControlE = ALU_ADD; ALUSrcE = 0; RegWriteE = 1;
        MemWriteE = 0; ResultSrcE = 0; RdE = rd; ForwardBE = FWD_REG; RD2_E = b;
        if (drain) begin
            ForwardAE = FWD_WB; ResultW = a; RD1_E = ~a;
        end else begin
            ForwardAE = FWD_REG; RD1_E = a;
        end
        stalls = 0; bad_bubble = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (StallEX === 1'b1) begin
                stalls++;
                @(posedge clk); #1;
                if (drain) ResultW = $urandom;
                if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || RdM !== 5'd0) bad_bubble++;
            end else begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        check32({name, " stall cycles"}, 32'(stalls), 32'd33);
        check32({name, " bubbles"}, 32'(bad_bubble), 32'd0);
        check32({name, " result"}, ALUResultM, exp);
        tests_run++;
        if (RegWriteM !== 1'b1 || RdM !== rd) begin
            tests_failed++;
            $display("FAIL %s writeback: got RegWriteM=%b RdM=%0d expected 1/%0d", name, RegWriteM, RdM, rd);
        end
        DivE = 0;
        m_alu = exp;
    endtask

    task automatic test_div;
        exec_div("div_-20_3", DIVOP_DIV, 32'hFFFFFFEC, 32'd3, 1'b0);
        check32("div_-20_3 const", ALUResultM, 32'hFFFFFFFA);
        exec_div("remu_7_0", DIVOP_REMU, 32'd7, 32'd0, 1'b0);
        exec_div("divu_7_0", DIVOP_DIVU, 32'd7, 32'd0, 1'b0);
        exec_div("div_ovf", DIVOP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        exec_div("rem_ovf", DIVOP_REM, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        exec_div("div_neg_0", DIVOP_DIV, 32'hFFFFFFF9, 32'd0, 1'b0);
        exec_div("rem_neg", DIVOP_REM, 32'hFFFFFFF9, 32'd2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            exec_div("rand_div", 2'($urandom), $urandom, (i == 3) ? 32'd1 : ($urandom >> (i * 3)), 1'($urandom));
        end
    endtask

    task automatic test_back_to_back;
        exec_div("b2b_1", DIVOP_DIVU, 32'd1000, 32'd7, 1'b0);
        exec_div("b2b_2", DIVOP_REM, 32'hFFFFFC18, 32'd7, 1'b0);
    endtask

    task automatic test_reset_mid_busy;
        DivE = 1; DivOpE = DIVOP_DIV; ForwardAE = FWD_REG; ForwardBE = FWD_REG;
        ALUSrcE = 0; RD1_E = 32'd100; RD2_E = 32'd7; RegWriteE = 1; RdE = 5'd9;
        for (int c = 0; c < 11; c++) @(posedge clk);
        #2 rst = 0;
        #1;
        tests_run++;
        if (StallEX !== 1'b0 || {RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_busy: got StallEX=%b RegWriteM=%b ALUResultM=%h expected 0/0/0", StallEX, RegWriteM, ALUResultM);
        end
        @(posedge clk); #1;
        DivE = 0; RegWriteE = 0;
        rst = 1;
        m_alu = 0;
        exec_div("after_reset", DIVOP_DIV, 32'd100, 32'd7, 1'b0);
    endtask
`else
    task automatic test_no_div;
        logic [4:0] rd;
        for (int i = 0; i < 4; i++) begin
            rd = 5'($urandom_range(1, 31));
            DivE = 1; DivOpE = 2'($urandom); ALUControlE = ALU_ADD; ALUSrcE = 0;
            ForwardAE = FWD_REG; ForwardBE = FWD_REG; RegWriteE = 1; MemWriteE = 0; RdE = rd;
            RD1_E = (i == 0) ? 32'd9 : $urandom;
            RD2_E = (i == 0) ? 32'd3 : $urandom;
            @(negedge clk);
            tests_run++;
            if (StallEX !== 1'b0) begin
                tests_failed++;
                $display("FAIL nodiv StallEX: got %b expected 0", StallEX);
            end
            @(posedge clk); #1;
            check32("nodiv ALUResultM", ALUResultM, 32'd0);
            tests_run++;
            if (RegWriteM !== 1'b1 || RdM !== rd) begin
                tests_failed++;
                $display("FAIL nodiv writeback: got %b/%0d expected 1/%0d", RegWriteM, RdM, rd);
            end
            m_alu = 0;
        end
        DivE = 0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_directed();
        test_forward();
        test_random_alu();
`ifdef RV32M_DIV_EN
        test_div();
        test_back_to_back();
        test_reset_mid_busy();
`else
        test_no_div();
`endif
        test_random_alu();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
